// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package pc_fetch_ctrl_pkg;

    localparam int          PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: redirect inputs, imem request/response and decode handshake.
interface pc_fetch_ctrl_if
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic            exc;
    logic            eret;
    logic [PC_W-1:0] epc;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_ready;

    // master: the fetch controller; slave: hazard logic, imem and decode around it
    modport master (
        input  br_taken, br_target, jmp, jmp_target, exc, eret, epc,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output br_taken, br_target, jmp, jmp_target, exc, eret, epc,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/pc_fetch_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC while decode stalls.
module pc_fetch_buf #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     d_instr,
    input  logic [PC_W-1:0] d_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: one outstanding imem request, redirect/kill handling,
// and a valid/ready delivery to decode with a skid buffer for stalls.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF)
) (
    input logic              clk,
    input logic              rst,
    pc_fetch_ctrl_if.master  bus
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] tgt_raw, tgt;
    logic            kill, kill_nxt;
    logic            redir;
    logic            req_c;
    logic            if_valid_c;
    logic [31:0]     if_instr_c;
    logic [PC_W-1:0] if_pc_c;
    logic            buf_load, buf_clear, buf_valid;
    logic [31:0]     buf_instr;
    logic [PC_W-1:0] buf_pc;

    assign redir = bus.exc | bus.eret | bus.jmp | bus.br_taken;

    always_comb begin
        tgt_raw = bus.br_target;
        if (bus.exc)       tgt_raw = EXC_VEC;
        else if (bus.eret) tgt_raw = bus.epc;
        else if (bus.jmp)  tgt_raw = bus.jmp_target;
    end

    assign tgt = {tgt_raw[PC_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        kill_nxt   = kill;
        req_c      = 1'b0;
        if_valid_c = 1'b0;
        if_instr_c = '0;
        if_pc_c    = pc;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
                if (redir) pc_nxt = tgt;
            end
            ST_REQ: begin
                req_c = 1'b1;
                if (redir) pc_nxt = tgt;
                if (bus.imem_gnt) begin
                    state_nxt = ST_WAIT;
                    // granted request targets the old pc, so its response must be dropped
                    kill_nxt  = redir;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_nxt = ST_REQ;
                    if (kill) begin
                        kill_nxt = 1'b0;
                        if (redir) pc_nxt = tgt;
                    end else begin
                        if_valid_c = ~redir;
                        if_instr_c = bus.imem_rdata;
                        if_pc_c    = pc;
                        if (redir) begin
                            pc_nxt = tgt;
                        end else if (bus.if_ready) begin
                            pc_nxt = pc + PC_W'(4);
                        end else begin
                            buf_load  = 1'b1;
                            state_nxt = ST_HOLD;
                        end
                    end
                end else if (redir) begin
                    pc_nxt   = tgt;
                    kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if_valid_c = buf_valid & ~redir;
                if_instr_c = buf_instr;
                if_pc_c    = buf_pc;
                if (redir) begin
                    pc_nxt    = tgt;
                    buf_clear = 1'b1;
                    state_nxt = ST_REQ;
                end else if (bus.if_ready) begin
                    pc_nxt    = pc + PC_W'(4);
                    buf_clear = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    pc_fetch_buf #(
        .PC_W (PC_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .d_instr (bus.imem_rdata),
        .d_pc    (pc),
        .valid   (buf_valid),
        .instr   (buf_instr),
        .pc      (buf_pc)
    );

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = if_valid_c;
    assign bus.if_instr  = if_instr_c;
    assign bus.if_pc     = if_pc_c;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: per-cycle vector table plus wrap and reset sequences.
module tb_pc_fetch_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   mem_dly;

    pc_fetch_ctrl_if #(.PC_W(32)) bus ();

    pc_fetch_ctrl #(
        .PC_W     (32),
        .RESET_PC (32'h0000_3000),
        .EXC_VEC  (32'h0000_4180)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem model: always grants, answers after mem_dly cycles, data = address
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    initial begin
        pend  = 1'b0;
        cnt   = 0;
        paddr = '0;
    end

    always @(posedge clk) begin
        if (pend) begin
            if (cnt == 1) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            pend  <= 1'b1;
            cnt   <= mem_dly;
            paddr <= bus.imem_addr;
        end
    end

    assign bus.imem_gnt    = bus.imem_req;
    assign bus.imem_rvalid = pend && (cnt == 1);
    assign bus.imem_rdata  = (pend && (cnt == 1)) ? paddr : 32'h0;

    typedef struct {
        logic        ready;
        int          dly;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rdy, int dly, logic req, logic [31:0] addr,
                                logic vld, logic [31:0] pc, logic [31:0] ins);
        vec_t t;
        t.ready = rdy;    t.dly = dly;
        t.br = 1'b0;      t.br_t = '0;
        t.jmp = 1'b0;     t.jmp_t = '0;
        t.exc = 1'b0;     t.eret = 1'b0;  t.epc = '0;
        t.e_req = req;    t.e_addr = addr;
        t.e_valid = vld;  t.chk_data = vld;
        t.e_pc = pc;      t.e_instr = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic clr_redir();
        bus.br_taken = 1'b0; bus.br_target = '0;
        bus.jmp = 1'b0;      bus.jmp_target = '0;
        bus.exc = 1'b0;      bus.eret = 1'b0; bus.epc = '0;
    endtask

    // leaves the bench at a negedge with imem_req high, or records a timeout
    task automatic wait_req(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL %s: imem_req never asserted within 20 cycles", name);
        else       pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        mem_dly   = 1;
        rst       = 1'b1;
        bus.if_ready = 1'b1;
        clr_redir();

        for (int i = 0; i < NV; i++) vecs[i] = mk(1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        vecs[0]  = mk(1, 1, 0, 32'h0,    0, 32'h3000, 32'h0);
        vecs[0].chk_data = 1'b1;
        vecs[1]  = mk(1, 1, 1, 32'h3000, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 32'h0,    1, 32'h3000, 32'h3000);
        vecs[3]  = mk(1, 1, 1, 32'h3004, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 32'h0,    1, 32'h3004, 32'h3004);
        for (int i = 5; i < 9; i++)
            vecs[i] = mk(0, 1, 0, 32'h0, 1, 32'h3004, 32'h3004);
        vecs[9]  = mk(1, 1, 0, 32'h0,    1, 32'h3004, 32'h3004);
        vecs[10] = mk(1, 1, 1, 32'h3008, 0, 0, 0);
        vecs[11] = mk(1, 1, 0, 32'h0,    1, 32'h3008, 32'h3008);
        vecs[12] = mk(1, 2, 1, 32'h300C, 0, 0, 0);
        vecs[13] = mk(1, 2, 0, 32'h0,    0, 0, 0);
        vecs[13].br = 1'b1; vecs[13].br_t = 32'h3100;
        vecs[14] = mk(1, 1, 0, 32'h0,    0, 0, 0);
        vecs[15] = mk(1, 1, 1, 32'h3100, 0, 0, 0);
        vecs[16] = mk(1, 1, 0, 32'h0,    1, 32'h3100, 32'h3100);
        vecs[17] = mk(1, 1, 1, 32'h3104, 0, 0, 0);
        vecs[17].exc = 1'b1;
        vecs[17].jmp = 1'b1; vecs[17].jmp_t = 32'h5000;
        vecs[17].br  = 1'b1; vecs[17].br_t  = 32'h3200;
        vecs[18] = mk(1, 1, 0, 32'h0,    0, 0, 0);
        vecs[19] = mk(1, 1, 1, 32'h4180, 0, 0, 0);
        vecs[20] = mk(1, 1, 0, 32'h0,    0, 0, 0);
        vecs[20].jmp = 1'b1; vecs[20].jmp_t = 32'h6003;
        vecs[21] = mk(1, 1, 1, 32'h6000, 0, 0, 0);
        vecs[22] = mk(1, 1, 0, 32'h0,    1, 32'h6000, 32'h6000);
        vecs[23] = mk(1, 1, 1, 32'h6004, 0, 0, 0);
        vecs[23].eret = 1'b1; vecs[23].epc = 32'h7002;
        vecs[23].jmp  = 1'b1; vecs[23].jmp_t = 32'h8000;
        vecs[24] = mk(1, 1, 0, 32'h0,    0, 0, 0);
        vecs[25] = mk(1, 1, 1, 32'h7000, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_pc",    bus.if_pc,             32'h3000);
        chk("rst_instr", bus.if_instr,          32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.if_ready   = vecs[i].ready;
            mem_dly        = vecs[i].dly;
            bus.br_taken   = vecs[i].br;   bus.br_target  = vecs[i].br_t;
            bus.jmp        = vecs[i].jmp;  bus.jmp_target = vecs[i].jmp_t;
            bus.exc        = vecs[i].exc;  bus.eret       = vecs[i].eret;
            bus.epc        = vecs[i].epc;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   {31'h0, bus.imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_valid", i), {31'h0, bus.if_valid}, {31'h0, vecs[i].e_valid});
            if (vecs[i].e_req)
                chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_pc", i),    bus.if_pc,    vecs[i].e_pc);
                chk($sformatf("v%0d_instr", i), bus.if_instr, vecs[i].e_instr);
            end
            @(posedge clk); #1;
        end
        clr_redir();
        bus.if_ready = 1'b1;
        mem_dly      = 1;

        // PC wrap: jump to the last word, deliver it, next fetch is address 0
        wait_req("wrap_req0");
        bus.jmp = 1'b1; bus.jmp_target = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        clr_redir();
        wait_req("wrap_req1");
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("wrap_pc",    bus.if_pc,             32'hFFFF_FFFC);
        chk("wrap_instr", bus.if_instr,          32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_next_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("wrap_next_addr", bus.imem_addr,         32'h0);

        // async reset while a slow response is outstanding
        mem_dly = 3;
        wait_req("rstw_req");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_pre_valid", {31'h0, bus.if_valid}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("rstw_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rstw_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rstw_pc",    bus.if_pc,             32'h3000);
        chk("rstw_instr", bus.if_instr,          32'h0);
        mem_dly = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstw_rvalid_seen", {31'h0, bus.imem_rvalid}, 32'h1);
        chk("rstw_rvalid_valid", {31'h0, bus.if_valid},   32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_c1_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rstw_c1_valid", {31'h0, bus.if_valid}, 32'h0);
        @(negedge clk);
        chk("rstw_c2_req",   {31'h0, bus.imem_req}, 32'h1);
        chk("rstw_c2_addr",  bus.imem_addr,         32'h3000);
        chk("rstw_c2_valid", {31'h0, bus.if_valid}, 32'h0);
        @(negedge clk);
        chk("rstw_c3_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("rstw_c3_pc",    bus.if_pc,             32'h3000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC and sequences instruction fetch: holds the PC, issues requests to instruction memory, and delivers fetched instructions to the decode stage with a valid/ready handshake.
- Applies redirects (exception, eret, jump, branch) and kills wrong-path fetches already in flight.
- Sits between the hazard/branch logic and imem. Replaces a free-running PC+4 path.
- No branch delay slot.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  PC_W  branch target
- jmp  in  1  jump this cycle
- jmp_target  in  PC_W  jump target
- exc  in  1  exception this cycle; redirect to EXC_VEC
- eret  in  1  exception return this cycle
- epc  in  PC_W  return address for eret
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; at most one outstanding request
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_pc  out  PC_W  PC of the delivered instruction
- if_instr  out  32  delivered instruction
- if_ready  in  1  decode accepts; the hazard unit holds this low to stall

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=IDLE, kill=0, buffer cleared.
  - Outputs: imem_req=0, if_valid=0, if_instr=0, if_pc=RESET_PC.
- redir = exc|eret|jmp|br_taken.
  - Target priority: exc(EXC_VEC) > eret(epc) > jmp(jmp_target) > br(br_target).
  - Target bits [1:0] are forced to 00.
- pc+4 wraps modulo 2^PC_W; 32'hFFFF_FFFC+4 gives 0.
- Delivery handshake: fire = if_valid & if_ready. if_valid is gated by ~redir, so a redirect always suppresses delivery in the same cycle.
- States:
  - IDLE: entered on reset.
    - Next cycle -> REQ.
    - A redirect here loads pc.
  - REQ: imem_req=1, imem_addr=pc.
    - gnt & ~redir -> WAIT.
    - gnt & redir -> pc<=target, kill<=1, -> WAIT.
    - ~gnt & redir -> pc<=target, stay REQ.
    - imem_req stays high until gnt; the address may change only on a redirect.
  - WAIT: imem_req=0.
    - On rvalid & kill: drop the data, kill<=0, -> REQ.
    - On rvalid & ~kill: if_valid=~redir, if_instr=imem_rdata, if_pc=pc, all combinational in the same cycle.
      - fire -> pc<=pc+4, -> REQ.
      - no fire and ~redir -> capture into the buffer, -> HOLD.
      - redir -> pc<=target, -> REQ, data dropped.
    - Redirect without rvalid: pc<=target, kill<=1, stay WAIT.
  - HOLD: if_valid=~redir, if_instr and if_pc driven from the buffer.
    - fire -> pc<=pc+4, -> REQ.
    - redir -> pc<=target, discard the buffer, -> REQ.
    - Otherwise hold; outputs stay stable while if_ready=0.
- Latency:
  - Zero-wait imem (gnt in REQ, rvalid the cycle after): one instruction every 2 cycles.
  - First if_valid after reset release: cycle 3.
- Simultaneous events:
  - Redirect + rvalid in WAIT: the redirect wins and the data is dropped; kill is not set, because that response was the outstanding one.
  - Redirect in the same cycle as gnt: kill is set.
- Invariants:
  - Never more than one outstanding request.
  - if_instr/if_pc are stable while if_valid=1 and if_ready=0 with no redirect.

Decomposition:
- defines.vh gains:
  - the PC width macro
  - RESET_PC and EXC_VEC
  - 2-bit state encodings: IDLE=0, REQ=1, WAIT=2, HOLD=3
- One sub-module, pc_fetch_buf: a 1-entry skid buffer (instr+pc, load/clear/valid) used by HOLD.
- PC register, next-PC mux and FSM stay in pc_fetch_ctrl.

Test Plan:
- Zero-wait imem returning addr as data, if_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 on alternate cycles; if_pc/if_instr match.
- if_ready=0 for 5 cycles after a response at pc 0x3004 -> HOLD; if_instr stable at 0x3004, no new imem_req; release -> pc becomes 0x3008.
- br_taken with br_target 0x3100 while in WAIT (rvalid 2 cycles later) -> stale data dropped with if_valid=0; next imem_addr=0x3100.
- exc, jmp and br_taken in the same cycle (jmp_target 0x5000) -> next imem_addr=0x4180.
- jmp_target 0x6003 -> imem_addr=0x6000; pc 0xFFFF_FFFC delivered -> next imem_addr=0x0000_0000.
- rst asserted mid-WAIT, with rvalid arriving during reset -> outputs reset immediately; after release first imem_addr=0x3000, no spurious if_valid.
